line_burst_responder: RTL

Memory-side responder for the cache's physical-memory port. It accepts one 256-bit line read or write, performs it as a fixed 4-beat, 64-bit burst on the backing-memory bus, and returns a single-cycle pmem_resp. It sits between the cache's pmem_* outputs and the main-memory/arbiter burst interface.

---
 rtl/line_burst_responder_pkg.sv | 26 ++
 rtl/line_burst_responder_buffer.sv | 42 ++++
 rtl/line_burst_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/line_burst_responder_pkg.sv
// Shared types and constants for the cache-line burst responder.
package line_burst_responder_pkg;

  localparam int BEAT_WIDTH  = 64;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_WIDTH  = BEATS * BEAT_WIDTH;
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  typedef logic [LINE_WIDTH-1:0] cacheline_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lbr_state_e;

  // Clears the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/line_burst_responder_buffer.sv
// Line buffer with full-line load, beat-indexed write and beat-indexed read.
module line_beat_buffer
  import line_burst_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  cacheline_t line_i,
  input  logic       wr_en_i,
  input  beat_idx_t  wr_idx_i,
  input  beat_t      wr_beat_i,
  input  beat_idx_t  rd_idx_i,
  output beat_t      rd_beat_o,
  output cacheline_t line_o
);

  cacheline_t line_q, line_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (wr_en_i) begin
      line_d[int'(wr_idx_i)*BEAT_WIDTH +: BEAT_WIDTH] = wr_beat_i;
    end
  end

  // NOTE: this storage is reset because the read line is visible on the port straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_beat_o = line_q[int'(rd_idx_i)*BEAT_WIDTH +: BEAT_WIDTH];
  assign line_o    = line_q;

endmodule

// File: rtl/line_burst_responder.sv
// Turns one 256-bit cache line request into a 4-beat 64-bit memory burst.
module line_burst_responder
  import line_burst_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pmem_address,
  input  cacheline_t  pmem_wdata,
  input  logic        pmem_read,
  input  logic        pmem_write,
  output cacheline_t  pmem_rdata,
  output logic        pmem_resp,
  output logic [31:0] burst_address,
  output logic        burst_read,
  output logic        burst_write,
  output beat_t       burst_wdata,
  input  beat_t       burst_rdata,
  input  logic        burst_resp
);

  lbr_state_e  state_q, state_d;
  beat_idx_t   cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        buf_load;
  logic        buf_wr_en;
  beat_t       buf_rd_beat;
  cacheline_t  buf_line;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    buf_load  = 1'b0;
    buf_wr_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Write wins when both requests are raised together.
        if (pmem_write) begin
          addr_d   = line_align(pmem_address);
          buf_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WRITE;
        end else if (pmem_read) begin
          addr_d  = line_align(pmem_address);
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (burst_resp) begin
          buf_wr_en = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == beat_idx_t'(BEATS - 1)) state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == beat_idx_t'(BEATS - 1)) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  line_beat_buffer u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load),
    .line_i    (pmem_wdata),
    .wr_en_i   (buf_wr_en),
    .wr_idx_i  (cnt_q),
    .wr_beat_i (burst_rdata),
    .rd_idx_i  (cnt_q),
    .rd_beat_o (buf_rd_beat),
    .line_o    (buf_line)
  );

  assign burst_read    = (state_q == ST_READ);
  assign burst_write   = (state_q == ST_WRITE);
  assign burst_address = addr_q;
  assign burst_wdata   = buf_rd_beat;
  assign pmem_resp     = (state_q == ST_RESP);
  assign pmem_rdata    = buf_line;

endmodule
